// File: rtl/apb_timer_pkg.sv
// Shared constants and types for the APB timer slave: register offsets, CTRL bit positions, APB FSM states.
// The optional prescaler is selected with the APB_TIMER_PRESCALER_EN macro.
package apb_timer_pkg;

   localparam logic [2:0] CTRL_OFS     = 3'd0;
   localparam logic [2:0] LOAD_OFS     = 3'd1;
   localparam logic [2:0] VALUE_OFS    = 3'd2;
   localparam logic [2:0] STATUS_OFS   = 3'd3;
   localparam logic [2:0] PRESCALE_OFS = 3'd4;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_AR_BIT    = 1;
   localparam int CTRL_IRQEN_BIT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_timer_counter.sv
// Prescaler, tick generation and 32-bit VALUE down-counter for the APB timer.
// The prescaler exists only when APB_TIMER_PRESCALER_EN is defined; otherwise it ticks every enabled cycle.
module apb_timer_counter
#(
`ifdef APB_TIMER_PRESCALER_EN
   parameter int          PRESCALE_W = 8,
`endif
   parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
   input  logic                  i_clk,
   input  logic                  i_rstN,
   input  logic                  i_enable,
   input  logic                  i_autoReload,
   input  logic                  i_loadWr,
   input  logic                  i_ctrlWr,
   input  logic [31:0]           i_loadData,
   input  logic [31:0]           i_reloadValue,
`ifdef APB_TIMER_PRESCALER_EN
   input  logic                  i_enableRise,
   input  logic [PRESCALE_W-1:0] i_prescale,
`endif
   output logic [31:0]           o_value,
   output logic                  o_expire,
   output logic                  o_oneShotClear
);

   logic [31:0] r_value;
   logic        w_tick;
   logic        w_tickTaken;

`ifdef APB_TIMER_PRESCALER_EN
   logic [PRESCALE_W-1:0] r_psc;
   logic                  w_pscWrap;

   assign w_pscWrap = (r_psc == i_prescale);
   assign w_tick    = i_enable && w_pscWrap;

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_psc <= '0;
      end else if (i_loadWr || i_enableRise) begin
         r_psc <= '0;
      end else if (i_enable) begin
         r_psc <= w_pscWrap ? '0 : r_psc + 1'b1;
      end
   end
`else
   assign w_tick = i_enable;
`endif

   // A simultaneous LOAD or CTRL write takes priority, so the tick is dropped entirely
   assign w_tickTaken    = w_tick && !i_loadWr && !i_ctrlWr;
   assign o_expire       = w_tickTaken && (r_value == 32'd0);
   assign o_oneShotClear = o_expire && !i_autoReload;

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_value <= RESET_LOAD;
      end else if (i_loadWr) begin
         r_value <= i_loadData;
      end else if (w_tickTaken) begin
         if (r_value != 32'd0) begin
            r_value <= r_value - 32'd1;
         end else if (i_autoReload) begin
            r_value <= i_reloadValue;
         end
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/apb_timer_slave.sv
// APB2 slave (no PREADY/PSLVERR) holding the timer register bank, read mux and interrupt.
// Define APB_TIMER_PRESCALER_EN to include the PRESCALE register and prescale counter.
module apb_timer_slave
   import apb_timer_pkg::*;
#(
   parameter int          PRESCALE_W = 8,
   parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Psel,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        irq
);

   apb_state_e  r_state;
   apb_state_e  w_nextState;
   logic        w_writeEn;
   logic        w_readEn;
   logic [2:0]  w_addr;
   logic [2:0]  r_ctrl;
   logic [31:0] r_load;
   logic        r_expired;
   logic [31:0] w_value;
   logic [31:0] w_rdata;
   logic        w_expire;
   logic        w_oneShotClear;
   logic        w_ctrlWr;
   logic        w_loadWr;
   logic        w_statusWr;
   logic        w_unused;

   assign w_addr   = Paddr[4:2];
   assign w_unused = ^{Paddr[31:5], Paddr[1:0]};

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The FSM lags the bus by one cycle: r_state==SETUP is the bus ACCESS cycle, where writes commit
   always_comb begin
      w_nextState = r_state;
      w_writeEn   = 1'b0;
      w_readEn    = Psel && !Penable && !Pwrite;
      case (r_state)
         IDLE: begin
            if (Psel && !Penable) begin
               w_nextState = SETUP;
            end
         end
         SETUP: begin
            if (Psel && Penable) begin
               w_nextState = ACCESS;
               w_writeEn   = Pwrite;
            end else begin
               w_nextState = IDLE;
            end
         end
         ACCESS: begin
            if (Psel && !Penable) begin
               w_nextState = SETUP;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign w_ctrlWr   = w_writeEn && (w_addr == CTRL_OFS);
   assign w_loadWr   = w_writeEn && (w_addr == LOAD_OFS);
   assign w_statusWr = w_writeEn && (w_addr == STATUS_OFS);

`ifdef APB_TIMER_PRESCALER_EN
   logic [PRESCALE_W-1:0] r_prescale;
   logic                  w_enableRise;

   assign w_enableRise = w_ctrlWr && Pwdata[CTRL_EN_BIT] && !r_ctrl[CTRL_EN_BIT];

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_prescale <= '0;
      end else if (w_writeEn && (w_addr == PRESCALE_OFS)) begin
         r_prescale <= Pwdata[PRESCALE_W-1:0];
      end
   end
`else
   logic [PRESCALE_W-1:0] w_unusedPrescale;
   assign w_unusedPrescale = '0;
`endif

   apb_timer_counter #(
`ifdef APB_TIMER_PRESCALER_EN
      .PRESCALE_W     (PRESCALE_W),
`endif
      .RESET_LOAD     (RESET_LOAD)
   ) u_counter (
      .i_clk          (Hclk),
      .i_rstN         (Hresetn),
      .i_enable       (r_ctrl[CTRL_EN_BIT]),
      .i_autoReload   (r_ctrl[CTRL_AR_BIT]),
      .i_loadWr       (w_loadWr),
      .i_ctrlWr       (w_ctrlWr),
      .i_loadData     (Pwdata),
      .i_reloadValue  (r_load),
`ifdef APB_TIMER_PRESCALER_EN
      .i_enableRise   (w_enableRise),
      .i_prescale     (r_prescale),
`endif
      .o_value        (w_value),
      .o_expire       (w_expire),
      .o_oneShotClear (w_oneShotClear)
   );

   // Expiry set beats a same-cycle W1C; a CTRL write beats the one-shot enable clear
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_ctrl    <= 3'b000;
         r_load    <= RESET_LOAD;
         r_expired <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (w_ctrlWr) begin
            r_ctrl <= Pwdata[2:0];
         end else if (w_oneShotClear) begin
            r_ctrl[CTRL_EN_BIT] <= 1'b0;
         end
         if (w_loadWr) begin
            r_load <= Pwdata;
         end
         if (w_expire) begin
            r_expired <= 1'b1;
         end else if (w_statusWr && Pwdata[0]) begin
            r_expired <= 1'b0;
         end
         irq <= r_expired && r_ctrl[CTRL_IRQEN_BIT];
      end
   end

   always_comb begin
      w_rdata = 32'd0;
      case (w_addr)
         CTRL_OFS:     w_rdata = {29'd0, r_ctrl};
         LOAD_OFS:     w_rdata = r_load;
         VALUE_OFS:    w_rdata = w_value;
         STATUS_OFS:   w_rdata = {31'd0, r_expired};
`ifdef APB_TIMER_PRESCALER_EN
         PRESCALE_OFS: w_rdata = 32'(r_prescale);
`endif
         default:      w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         Prdata <= 32'd0;
      end else if (w_readEn) begin
         Prdata <= w_rdata;
      end
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed scenarios plus randomized APB traffic against a register-level model.
// Honours APB_TIMER_PRESCALER_EN the same way as the design.
module tb_apb_timer_slave;

   localparam logic [31:0] RESET_LOAD = 32'hFFFF_FFFF;
   localparam logic [31:0] A_CTRL     = 32'h00;
   localparam logic [31:0] A_LOAD     = 32'h04;
   localparam logic [31:0] A_VALUE    = 32'h08;
   localparam logic [31:0] A_STATUS   = 32'h0C;
   localparam logic [31:0] A_PRESCALE = 32'h10;

   logic        Hclk;
   logic        Hresetn;
   logic        Psel;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // Model state: the programmer-visible registers plus the prescale count
   logic [2:0]  mCtrl;
   logic [31:0] mLoad;
   logic [31:0] mValue;
   logic        mExpired;
   logic [7:0]  mPrescale;
   logic [7:0]  mPsc;
   logic        mIrq;
   logic [31:0] mPrdata;

   apb_timer_slave #(
      .PRESCALE_W (8),
      .RESET_LOAD (RESET_LOAD)
   ) dut (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .Psel    (Psel),
      .Penable (Penable),
      .Pwrite  (Pwrite),
      .Paddr   (Paddr),
      .Pwdata  (Pwdata),
      .Prdata  (Prdata),
      .irq     (irq)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   function automatic logic [31:0] modelRead(input logic [2:0] ofs);
      case (ofs)
         3'd0: return {29'd0, mCtrl};
         3'd1: return mLoad;
         3'd2: return mValue;
         3'd3: return {31'd0, mExpired};
`ifdef APB_TIMER_PRESCALER_EN
         3'd4: return {24'd0, mPrescale};
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelReset();
      mCtrl     = 3'd0;
      mLoad     = RESET_LOAD;
      mValue    = RESET_LOAD;
      mExpired  = 1'b0;
      mPrescale = 8'd0;
      mPsc      = 8'd0;
      mIrq      = 1'b0;
      mPrdata   = 32'd0;
   endtask

   task automatic modelStep();
      logic [2:0]  ofs;
      logic        wr, rd, wrCtrl, wrLoad, tick, expire, nIrq;
      logic [31:0] nValue;
      logic [2:0]  nCtrl;
      logic        nExp;
      logic [7:0]  nPsc;
      ofs    = Paddr[4:2];
      wr     = Psel && Penable && Pwrite;
      rd     = Psel && !Penable && !Pwrite;
      wrCtrl = wr && (ofs == 3'd0);
      wrLoad = wr && (ofs == 3'd1);
`ifdef APB_TIMER_PRESCALER_EN
      tick = mCtrl[0] && (mPsc == mPrescale);
`else
      tick = mCtrl[0];
`endif
      nIrq   = mExpired && mCtrl[2];
      nValue = mValue;
      nCtrl  = mCtrl;
      nExp   = mExpired;
      nPsc   = mPsc;
      expire = 1'b0;
      if (rd) mPrdata = modelRead(ofs);
      if (tick && !wrCtrl && !wrLoad) begin
         if (mValue != 32'd0) nValue = mValue - 32'd1;
         else begin
            expire = 1'b1;
            if (mCtrl[1]) nValue = mLoad;
            else nCtrl[0] = 1'b0;
         end
      end
      if (mCtrl[0]) nPsc = (mPsc == mPrescale) ? 8'd0 : mPsc + 8'd1;
      if (wrLoad || (wrCtrl && Pwdata[0] && !mCtrl[0])) nPsc = 8'd0;
      if (expire) nExp = 1'b1;
      if (wr) begin
         case (ofs)
            3'd0: nCtrl = Pwdata[2:0];
            3'd1: begin mLoad = Pwdata; nValue = Pwdata; end
            3'd3: if (Pwdata[0] && !expire) nExp = 1'b0;
`ifdef APB_TIMER_PRESCALER_EN
            3'd4: mPrescale = Pwdata[7:0];
`endif
            default: ;
         endcase
      end
      mValue   = nValue;
      mCtrl    = nCtrl;
      mExpired = nExp;
      mPsc     = nPsc;
      mIrq     = nIrq;
   endtask

   always @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) modelReset();
      else modelStep();
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Each call is one bus cycle: irq is compared at the falling edge, then the bus is driven
   task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
      @(negedge Hclk);
      checkOutput("irq", {31'd0, irq}, {31'd0, mIrq});
      Psel    = sel;
      Penable = en;
      Pwrite  = wr;
      Paddr   = addr;
      Pwdata  = data;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
      applyStimulus(1'b1, 1'b1, 1'b1, addr, data);
   endtask

   task automatic apbRead(input logic [31:0] addr, input string tag);
      applyStimulus(1'b1, 1'b0, 1'b0, addr, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'd0);
      checkOutput(tag, Prdata, mPrdata);
   endtask

   task automatic apbReadExpect(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      apbRead(addr, {tag, "_model"});
      checkOutput(tag, Prdata, exp);
   endtask

   initial begin
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  ofs;
      int unsigned op;

      Hresetn = 1'b0;
      Psel    = 1'b0;
      Penable = 1'b0;
      Pwrite  = 1'b0;
      Paddr   = 32'd0;
      Pwdata  = 32'd0;
      repeat (2) @(negedge Hclk);
      Hresetn = 1'b1;
      $display("[TB] reset released");

      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         data = (i == 1 || i == 2) ? RESET_LOAD : 32'd0;
         apbReadExpect(32'(i * 4), data, $sformatf("rst_ofs%0d", i));
      end
      idle(1);

      // Auto-reload with prescale 0: back-to-back VALUE reads two cycles apart
      apbWrite(A_PRESCALE, 32'd0);
      apbWrite(A_LOAD, 32'd5);
      apbWrite(A_CTRL, 32'd7);
      apbReadExpect(A_VALUE, 32'd5, "ar_value0");
      apbReadExpect(A_VALUE, 32'd3, "ar_value1");
      apbReadExpect(A_VALUE, 32'd1, "ar_value2");
      apbReadExpect(A_VALUE, 32'd5, "ar_reload");
      idle(1);
      apbReadExpect(A_STATUS, 32'd1, "ar_expired");
      checkOutput("ar_irq", {31'd0, irq}, 32'd1);
      apbWrite(A_CTRL, 32'd0);
      apbWrite(A_STATUS, 32'd1);
      idle(2);

      // One-shot with prescale 3
      apbWrite(A_PRESCALE, 32'd3);
      apbWrite(A_LOAD, 32'd2);
      apbWrite(A_CTRL, 32'd5);
      idle(30);
      apbReadExpect(A_CTRL, 32'd4, "os_ctrl");
      apbReadExpect(A_VALUE, 32'd0, "os_value");
      apbReadExpect(A_STATUS, 32'd1, "os_expired");
      idle(1);

      // W1C clears expired and irq follows one cycle later
      apbWrite(A_STATUS, 32'd1);
      idle(2);
      apbReadExpect(A_STATUS, 32'd0, "w1c_cleared");
      checkOutput("w1c_irq", {31'd0, irq}, 32'd0);
      idle(1);

      // W1C lands on the expiry edge: the set must win
      apbWrite(A_PRESCALE, 32'd0);
      apbWrite(A_LOAD, 32'd1);
      idle(1);
      apbWrite(A_CTRL, 32'd5);
      apbWrite(A_STATUS, 32'd1);
      idle(1);
      apbReadExpect(A_STATUS, 32'd1, "w1c_collide");
      idle(1);

      // Back-to-back write then read; VALUE is read-only
      apbWrite(A_LOAD, 32'h10);
      apbReadExpect(A_VALUE, 32'h10, "b2b_value");
      idle(1);
      apbWrite(A_VALUE, 32'h55);
      apbReadExpect(A_VALUE, 32'h10, "value_ro");
      idle(1);

      for (int i = 0; i < 150; i++) begin
         op    = $urandom_range(0, 9);
         ofs   = 3'($urandom_range(0, 7));
         addr  = $urandom;
         addr[4:2] = ofs;
         addr[1:0] = 2'b00;
         data  = $urandom;
         if (ofs == 3'd1) data = 32'($urandom_range(0, 12));
         if (ofs == 3'd4) data = {data[31:8], 8'($urandom_range(0, 3))};
         if (op < 6) apbWrite(addr, data);
         else apbRead(addr, $sformatf("rnd_read%0d_ofs%0d", i, ofs));
         idle(int'($urandom_range(0, 2)));
      end
      idle(2);

      // Reset asserted in the ACCESS cycle of a LOAD write
      apbWrite(A_CTRL, 32'd6);
      apbWrite(A_PRESCALE, 32'd2);
      apbWrite(A_STATUS, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, A_LOAD, 32'hAB);
      applyStimulus(1'b1, 1'b1, 1'b1, A_LOAD, 32'hAB);
      #2 Hresetn = 1'b0;
      idle(1);
      checkOutput("mid_rst_irq", {31'd0, irq}, 32'd0);
      Hresetn = 1'b1;
      idle(1);
      apbReadExpect(A_LOAD, RESET_LOAD, "mid_rst_load");
      checkOutput("mid_rst_not_ab", {31'd0, Prdata !== 32'hAB}, 32'd1);
      apbReadExpect(A_CTRL, 32'd0, "mid_rst_ctrl");
      apbReadExpect(A_VALUE, RESET_LOAD, "mid_rst_value");
      apbReadExpect(A_STATUS, 32'd0, "mid_rst_status");
      apbReadExpect(A_PRESCALE, 32'd0, "mid_rst_prescale");
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
